// File: rtl/kaktovik_scan_driver.sv
// Kaktovik scan driver: converts a 16-bit value to four base-20 digits by
// serial restoring division, double-buffers them, and time-multiplexes the
// digit outputs across four one-hot enables with ripple-blank support.
module kaktovik_scan_driver #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        busy,
  output logic        done,
  output logic [4:0]  digit_code,
  output logic        rbi,
  output logic [3:0]  sel
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PLast = PW'(SCAN_DIV - 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e           state;
  logic [15:0]      work;
  logic [4:0]       rem;
  logic [3:0]       bit_cnt;
  logic [1:0]       dig_cnt;
  logic [3:0][4:0]  pend;
  logic [3:0][4:0]  disp;

  logic [PW-1:0]    presc;
  logic [1:0]       idx;

  logic [5:0]       trial;
  logic             ge20;
  logic [4:0]       rem_nxt;
  logic [15:0]      work_nxt;
  logic             finish;
  logic [3:0][4:0]  disp_nxt;
  logic             wrap;
  logic [1:0]       idx_nxt;

  // One division step, end-of-conversion detect and scan-index advance.
  always_comb begin
    trial    = {rem, work[15]};
    ge20     = (trial >= 6'd20);
    rem_nxt  = ge20 ? 5'(trial - 6'd20) : trial[4:0];
    work_nxt = {work[14:0], ge20};
    finish   = (state == StConv) && (bit_cnt == 4'd15) && (dig_cnt == 2'd3);
    disp_nxt = disp;
    // The last remainder goes straight to the display alongside the pending ones.
    if (finish) disp_nxt = {rem_nxt, pend[2], pend[1], pend[0]};
    wrap    = (presc == PLast);
    idx_nxt = wrap ? idx + 2'd1 : idx;
  end

  // Conversion FSM: 4 digits x 16 division steps, then publish to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      work    <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      dig_cnt <= '0;
      pend    <= '0;
      disp    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (load) begin
            work    <= value;
            rem     <= '0;
            bit_cnt <= '0;
            dig_cnt <= '0;
            busy    <= 1'b1;
            state   <= StConv;
          end
        end
        StConv: begin
          bit_cnt <= bit_cnt + 4'd1;
          work    <= work_nxt;
          if (bit_cnt == 4'd15) begin
            // Quotient stays in work as the dividend for the next digit.
            rem           <= '0;
            pend[dig_cnt] <= rem_nxt;
            dig_cnt       <= dig_cnt + 2'd1;
            if (dig_cnt == 2'd3) begin
              disp  <= disp_nxt;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end
          end else begin
            rem <= rem_nxt;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Free-running scan prescaler; sel and digit_code are loaded from next-state
  // values so they always match the current index and display contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      sel        <= 4'b0001;
      digit_code <= '0;
    end else begin
      presc      <= wrap ? '0 : presc + PW'(1);
      idx        <= idx_nxt;
      sel        <= 4'b0001 << idx_nxt;
      digit_code <= disp_nxt[idx_nxt];
    end
  end

  // Ripple-blank: a zero digit is blanked only if every more-significant digit is zero.
  always_comb begin
    case (idx)
      2'd3:    rbi = ~blank_lz;
      2'd2:    rbi = ~blank_lz | (disp[3] != 5'd0);
      2'd1:    rbi = ~blank_lz | (disp[3] != 5'd0) | (disp[2] != 5'd0);
      default: rbi = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_kaktovik_scan_driver.sv
// Self-checking bench for kaktovik_scan_driver: directed scenarios plus
// randomized loads, all compared against an arithmetic reference model.
module tb_kaktovik_scan_driver;

  localparam int unsigned ScanDiv = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic [4:0]  digit_code;
  logic        rbi;
  logic [3:0]  sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kaktovik_scan_driver #(
    .SCAN_DIV (ScanDiv)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .busy       (busy),
    .done       (done),
    .digit_code (digit_code),
    .rbi        (rbi),
    .sel        (sel)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int pow20(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 20;
    return p;
  endfunction

  function automatic int exp_digit(input int shown, input int pos);
    return (shown / pow20(pos)) % 20;
  endfunction

  // A zero digit may be blanked only if the displayed number has nothing above it.
  function automatic int exp_rbi(input int shown, input int pos, input logic blz);
    return (!blz || pos == 0 || shown >= pow20(pos + 1)) ? 1 : 0;
  endfunction

  // Reference model: edges since reset, remaining busy cycles, shown value.
  int m_edges;
  int m_cnt;
  int m_val;
  int m_shown;
  bit m_done;
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_edges <= 0;
      m_cnt   <= 0;
      m_shown <= 0;
      m_done  <= 1'b0;
    end else begin
      m_edges <= m_edges + 1;
      m_done  <= 1'b0;
      if (m_cnt == 0) begin
        if (load) begin
          m_val <= int'(value);
          m_cnt <= 64;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_shown <= m_val;
          m_done  <= 1'b1;
        end
      end
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    int pos;
    if (mon_en) begin
      pos = (m_edges / ScanDiv) % 4;
      check_eq("busy", busy, (m_cnt != 0) ? 1 : 0);
      check_eq("done", done, m_done ? 1 : 0);
      check_eq("sel", sel, 1 << pos);
      check_eq("digit_code", digit_code, exp_digit(m_shown, pos));
      check_eq("rbi", rbi, exp_rbi(m_shown, pos, blank_lz));
    end
  end

  int dig[4];
  int rb[4];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step(1);
    load  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      step(1);
      i++;
    end
    if (!done) check_eq("done_timeout", 0, 1);
  endtask

  // Observe one full scan sweep and record digit and rbi per position.
  task automatic collect();
    for (int k = 0; k < 4; k++) begin
      dig[k] = -1;
      rb[k]  = -1;
    end
    for (int c = 0; c < 4 * ScanDiv; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (sel == (4'b0001 << k)) begin
          dig[k] = int'(digit_code);
          rb[k]  = int'(rbi);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_digits(input string tag, input int d3, input int d2, input int d1,
                              input int d0);
    check_eq({tag, "_d3"}, dig[3], d3);
    check_eq({tag, "_d2"}, dig[2], d2);
    check_eq({tag, "_d1"}, dig[1], d1);
    check_eq({tag, "_d0"}, dig[0], d0);
  endtask

  task automatic check_rbis(input string tag, input int r3, input int r2, input int r1,
                            input int r0);
    check_eq({tag, "_rbi3"}, rb[3], r3);
    check_eq({tag, "_rbi2"}, rb[2], r2);
    check_eq({tag, "_rbi1"}, rb[1], r1);
    check_eq({tag, "_rbi0"}, rb[0], r0);
  endtask

  initial begin
    int c;
    int v;
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    step(2);
    mon_en = 1'b1;
    check_eq("rst_sel", sel, 1);
    check_eq("rst_digit", digit_code, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;
    step(3);

    // Scenario 1: max value, busy exactly 64 cycles.
    do_load(16'd65535);
    c = 0;
    while (busy && c < 200) begin
      c++;
      step(1);
    end
    check_eq("s1_busy_len", c, 64);
    check_eq("s1_done", done, 1);
    collect();
    check_digits("s1", 8, 3, 16, 15);

    // Scenario 2: 400 with leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'd400);
    wait_done(200);
    collect();
    check_digits("s2", 0, 1, 0, 0);
    check_rbis("s2", 0, 0, 1, 1);

    // Scenario 3: zero, blanking on then off.
    do_load(16'd0);
    wait_done(200);
    collect();
    check_digits("s3", 0, 0, 0, 0);
    check_rbis("s3_blz1", 0, 0, 0, 1);
    blank_lz = 1'b0;
    collect();
    check_rbis("s3_blz0", 1, 1, 1, 1);

    // Scenario 4: a load during busy is ignored.
    do_load(16'd12345);
    step(9);
    do_load(16'd999);
    wait_done(200);
    collect();
    check_digits("s4", 1, 10, 17, 5);

    // Scenario 5: reset mid-conversion aborts without done.
    do_load(16'd777);
    step(29);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("s5_busy", busy, 0);
    check_eq("s5_done", done, 0);
    check_eq("s5_sel", sel, 1);
    collect();
    check_digits("s5_cleared", 0, 0, 0, 0);
    step(60);
    do_load(16'd777);
    wait_done(200);
    collect();
    check_digits("s5", 0, 1, 18, 17);

    // Randomized loads, back-to-back reloads and ignored loads during busy.
    for (int it = 0; it < 25; it++) begin
      blank_lz = 1'($urandom_range(0, 1));
      v = int'($urandom_range(0, 65535));
      do_load(16'(v));
      if ($urandom_range(0, 1) == 1) begin
        step(int'($urandom_range(1, 50)));
        do_load(16'($urandom_range(0, 65535)));
      end
      wait_done(200);
      if ($urandom_range(0, 2) != 0) begin
        collect();
        check_digits("rand", exp_digit(v, 3), exp_digit(v, 2), exp_digit(v, 1),
                     exp_digit(v, 0));
        step(int'($urandom_range(0, 10)));
      end
    end
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
